uart_tx_serializer: RTL
=======================

Name: uart_tx_serializer

Overview:
UART transmit serializer that sits directly downstream of the TX FIFO. It accepts one byte per frame on a valid strobe and asserts tx_busy to stall further reads from the FIFO. Each byte is sent on the serial line as start bit, data bits LSB first, an optional parity bit, and 1 or 2 stop bits. The bit period is set by an internal baud counter.

Parameters:
DATA_WIDTH, 8, data bits per frame (5..9)
CLKS_PER_BIT, 868, clk cycles per serial bit (>=2; 868 = 100 MHz / 115200)
PARITY_EN, 0, 1 = insert parity bit after data bits
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored if PARITY_EN=0)
STOP_BITS, 1, number of stop bits (1 or 2)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
tx_data  in  DATA_WIDTH  byte to send (FIFO buff_out)
tx_valid  in  1  tx_data valid this cycle (FIFO data_valid)
tx_busy  out  1  high while a frame is in progress; drives FIFO tx_busy
tx  out  1  serial output line, idle high
tx_done  out  1  one-cycle pulse at end of the last stop bit

Behaviour:
- Reset and clock: rst_n is asynchronous and active-low; clk is the only clock. All outputs are registered.
- Reset values: tx=1, tx_busy=0, tx_done=0, state=IDLE, baud counter=0, bit index=0, shift register=0.
- FSM states: IDLE -> START -> DATA -> (PARITY if PARITY_EN) -> STOP -> IDLE.
- IDLE:
  - tx=1, tx_busy=0.
  - If tx_valid=1 in cycle N: tx_data is latched into the shift register, parity is computed from tx_data, and the FSM moves to START.
  - In cycle N+1: tx=0 and tx_busy=1.
  - tx_busy must be high at N+1 so that the FIFO pops exactly one entry.
- Bit timing:
  - The baud counter runs 0..CLKS_PER_BIT-1 in every non-IDLE state.
  - Each bit is held for exactly CLKS_PER_BIT cycles.
  - The state or bit advances on the cycle the counter equals CLKS_PER_BIT-1, and the counter then wraps to 0.
  - Counter width is $clog2(CLKS_PER_BIT).
- DATA:
  - tx = shift[0]; the register shifts right once per bit.
  - Bit index runs 0..DATA_WIDTH-1. After bit DATA_WIDTH-1 the FSM goes to PARITY if enabled, else to STOP.
- PARITY: tx = (XOR of latched data) XOR PARITY_ODD.
- STOP:
  - tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - On the final cycle of the final stop bit: tx_done=1 for that single cycle, and the FSM returns to IDLE.
  - tx_busy=0 from the following cycle.
- Frame length: (1 + DATA_WIDTH + PARITY_EN + STOP_BITS) * CLKS_PER_BIT cycles, measured from the first tx=0 cycle to the end of the last stop bit.
- Back-to-back frames:
  - tx_valid in the first IDLE cycle after a frame is accepted.
  - Frames are therefore separated by exactly one extra idle-high cycle.
- tx_valid while tx_busy=1 is ignored: no latch, and the current frame is not disturbed.
- tx_data is sampled only in the accepting cycle. Changes afterwards have no effect on the frame.
- Reset mid-frame: tx returns to 1 and tx_busy to 0 immediately (asynchronously). The partial frame is abandoned and no tx_done is generated.
- Illegal parameter values (STOP_BITS not 1/2, CLKS_PER_BIT<2) must fail elaboration via static assertion.

Test Plan:
- Reset, no tx_valid for 50 cycles -> tx=1, tx_busy=0, tx_done=0 throughout.
- CLKS_PER_BIT=4, PARITY_EN=0, STOP_BITS=1; send 0xA5 -> tx=0 for 4 cycles; then data bits 1,0,1,0,0,1,0,1, each held 4 cycles; then tx=1 for 4 cycles; frame spans 40 cycles; tx_done pulses once in cycle 40; tx_busy high cycles 1..40.
- PARITY_EN=1, send 0xA5 -> parity bit 0 for even; repeat with PARITY_ODD=1 -> parity bit 1; frame 44 cycles.
- Model the FIFO with 3 entries (0x01, 0x80, 0xFF) and connect data_valid/tx_busy -> exactly 3 frames with correct bits; one idle-high cycle between frames; 3 tx_done pulses; FIFO empty at the end.
- Hold tx_valid=1 with changing tx_data throughout a frame -> only the byte present in the accept cycle is transmitted; no extra frame starts until tx_busy falls.
- Assert rst_n=0 during data bit 3 -> tx=1 and tx_busy=0 in the same cycle with no tx_done; after release, a new 0x3C frame is sent correctly.
- STOP_BITS=2 -> stop phase is 8 cycles; tx_done only at the end of the second stop bit.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, DATA_WIDTH bits LSB first, optional parity, 1-2 stop bits.
// Latency: tx drops to the start bit the cycle after tx_valid is accepted in IDLE; frame is
//          (1 + DATA_WIDTH + PARITY_EN + STOP_BITS) * CLKS_PER_BIT cycles long.
// Backpressure: tx_busy is high for the whole frame; tx_valid is ignored while busy.
//
// Ports:
//   clk, rst_n      clock and asynchronous active-low reset
//   tx_data         byte to send, sampled only in the accepting cycle
//   tx_valid        tx_data valid (FIFO data_valid)
//   tx_busy         frame in progress, stalls the upstream FIFO
//   tx              serial line, idle high
//   tx_done         one-cycle pulse during the final cycle of the last stop bit
module uart_tx_serializer #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_busy,
    output logic                  tx,
    output logic                  tx_done
);

    generate
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
            $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
        end
        if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
            $error("uart_tx_serializer: CLKS_PER_BIT must be >= 2");
        end
        if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_data_width
            $error("uart_tx_serializer: DATA_WIDTH must be 5..9");
        end
    endgenerate

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = $clog2(DATA_WIDTH);

    localparam logic [CW-1:0] CNT_MAX       = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_DATA_LAST = IW'(DATA_WIDTH - 1);
    localparam logic [IW-1:0] IDX_STOP_LAST = IW'(STOP_BITS - 1);
    localparam logic          PAR_ODD       = (PARITY_ODD != 0);
    localparam logic          PAR_EN        = (PARITY_EN != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;      // data bit index, reused as stop bit index
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic                    par_q, par_d;
    logic                    tx_d, busy_d, done_d;
    logic                    bit_end;

    assign bit_end = (cnt_q == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx      <= 1'b1;
            tx_busy <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx      <= tx_d;
            tx_busy <= busy_d;
            tx_done <= done_d;
        end
    end

    // Next-state logic for FSM, baud counter, bit index and shift register.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;
        cnt_d   = bit_end ? '0 : cnt_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (tx_valid) begin
                    shift_d = tx_data;
                    par_d   = (^tx_data) ^ PAR_ODD;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    idx_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[DATA_WIDTH-1:1]};
                    if (idx_q == IDX_DATA_LAST) begin
                        idx_d   = '0;
                        state_d = PAR_EN ? S_PARITY : S_STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    idx_d   = '0;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (idx_q == IDX_STOP_LAST) begin
                        idx_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up
    // with the state they describe (no extra cycle of output latency).
    always_comb begin
        tx_d   = 1'b1;
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_STOP) && (cnt_d == CNT_MAX) && (idx_d == IDX_STOP_LAST);
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = par_d;
            default:  tx_d = 1'b1;
        endcase
    end

endmodule
